sram_port_arbiter: RTL and testbench
====================================

// Module: sram_port_arbiter
// PURPOSE
//  Shares one SRAM-like memory port between the IF-stage inst requester and the MEM-stage data requester.
//  Sits between the CPU core and the AXI bridge (or unified SRAM).
//  Arbitrates requests, locks a grant until addr_ok, and tags every accepted request in an order FIFO.
//  Each mem_data_ok / mem_rdata is steered back to the requester that issued it; the slave returns
//  responses in acceptance order.
// PARAMETERS
//  OUTSTANDING  2  max accepted-but-unanswered requests (tag FIFO depth, power of 2, >=2)
// PORTS
//  clk           in   1   clock
//  reset         in   1   synchronous active-high reset
//  inst_req      in   1   inst request valid
//  inst_wr       in   1   inst write (IF drives 0)
//  inst_size     in   2   inst size: 0=byte, 1=half, 2=word
//  inst_addr     in   32  inst address
//  inst_wstrb    in   4   inst byte strobe
//  inst_wdata    in   32  inst write data
//  inst_addr_ok  out  1   inst request accepted this cycle
//  inst_data_ok  out  1   inst response this cycle
//  inst_rdata    out  32  inst read data
//  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata   in   same widths as inst_*
//  data_addr_ok, data_data_ok, data_rdata                            out  same widths as inst_*
//  mem_req, mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata         out  muxed request to slave
//  mem_addr_ok   in   1   slave accepted mem request
//  mem_data_ok   in   1   slave response valid
//  mem_rdata     in   32  slave read data
//  arb_err       out  1   sticky: mem_data_ok seen while tag FIFO empty
// BEHAVIOUR
//  FSM (registered), 3 states:
//   IDLE       no locked grant; grant = data_req ? DATA : inst_req ? INST : none (data has fixed priority).
//   LOCK_INST  grant fixed to INST.
//   LOCK_DATA  grant fixed to DATA.
//  Transitions:
//   IDLE -> LOCK_x   when mem_req && !mem_addr_ok with grant x.
//   LOCK_x -> IDLE   on mem_req && mem_addr_ok, or when x_req drops (protocol violation, recover).
//   Under lock, a new higher-priority request never preempts the locked one.
//  Request muxing:
//   mem_req = granted x_req && !fifo_full.
//   mem_wr/size/addr/wstrb/wdata = granted requester's fields; all 0 when no grant.
//  Accept:
//   x_addr_ok = mem_addr_ok && mem_req && grant==x (combinational); never both asserted in one cycle.
//   Accept pushes tag (0=INST, 1=DATA) at wr_ptr.
//  Response:
//   when mem_data_ok && !fifo_empty: pop head; head tag selects which x_data_ok = 1.
//   inst_rdata = data_rdata = mem_rdata (unconditional passthrough).
//   mem_data_ok with empty FIFO: both x_data_ok = 0; arb_err set until reset.
//  FIFO:
//   wr_ptr/rd_ptr of log2(OUTSTANDING) bits wrap modulo depth; count 0..OUTSTANDING.
//   Push and pop in the same cycle: count unchanged, both pointers advance.
//   full = count==OUTSTANDING gates mem_req. No same-cycle pop bypass, so no data_ok->req comb path.
//   Zero added latency: request and response paths are combinational through the block.
//  Reset (sync, same edge):
//   FSM=IDLE, ptrs=0, count=0, arb_err=0.
//   All outputs 0 while reset is high, except rdata, which follows mem_rdata.
//   Reset mid-transaction drops all tags; later data_ok for dropped tags sets arb_err.
//   System reset also resets the slave, so this does not occur in normal use.
// TESTING
//  T1 inst_req=1 only, mem_addr_ok=1 at cycle 0, mem_data_ok at cycle 2 with rdata=32'h1c00_0000
//     -> inst_addr_ok@0, inst_data_ok@2, inst_rdata=32'h1c00_0000, data_* low.
//  T2 inst_req and data_req both high, mem_addr_ok=1 -> data accepted first, inst next cycle;
//     responses return in order as data_data_ok then inst_data_ok.
//  T3 inst_req high, mem_addr_ok=0 for 3 cycles, data_req rises in cycle 1
//     -> mem_addr stays inst_addr through acceptance at cycle 3; data accepted at cycle 4.
//  T4 OUTSTANDING=2, two accepts with no data_ok -> mem_req=0 on 3rd request;
//     data_ok then pop -> mem_req=1 next cycle.
//  T5 push and pop in the same cycle, repeated for 8 cycles with alternating tags
//     -> count stays 1, pointers wrap, every data_ok routed to the correct requester.
//  T6 mem_data_ok with FIFO empty -> no x_data_ok, arb_err=1 and held;
//     reset mid-lock -> FSM IDLE, arb_err=0, next cycle arbitrates afresh.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one SRAM-like port between the IF-stage (inst)
// and MEM-stage (data) requesters. Data has fixed priority when no grant is
// locked. A stalled grant stays locked until the slave accepts it. Every
// accepted request leaves a tag in an order FIFO so that each in-order
// response can be steered back to the requester that issued it.
module sram_port_arbiter #(
  parameter int OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,

  output logic        arb_err
);

  localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(OUTSTANDING + 1);

  localparam logic TAG_INST = 1'b0;
  localparam logic TAG_DATA = 1'b1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOCK_INST = 2'd1,
    LOCK_DATA = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_INST = 2'd1,
    GNT_DATA = 2'd2
  } gnt_t;

  state_t             state_q;
  gnt_t               gnt;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_d;
  logic               tag_q [OUTSTANDING];
  logic               arb_err_q;

  logic fifo_full;
  logic fifo_empty;
  logic accept;
  logic pop;
  logic head_tag;

  assign fifo_full  = (count_q == CNT_W'(OUTSTANDING));
  assign fifo_empty = (count_q == '0);

  // Grant selection: a lock pins the grant; otherwise data wins over inst.
  // Reset suppresses every grant so the port is silent while reset is high.
  always_comb begin
    gnt = GNT_NONE;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (data_req)      gnt = GNT_DATA;
          else if (inst_req) gnt = GNT_INST;
        end
        LOCK_INST: gnt = GNT_INST;
        LOCK_DATA: gnt = GNT_DATA;
        default:   gnt = GNT_NONE;
      endcase
    end
  end

  // Request mux toward the slave; a full tag FIFO holds the request back.
  always_comb begin
    mem_req   = 1'b0;
    mem_wr    = 1'b0;
    mem_size  = 2'd0;
    mem_addr  = 32'd0;
    mem_wstrb = 4'd0;
    mem_wdata = 32'd0;
    case (gnt)
      GNT_INST: begin
        mem_req   = inst_req && !fifo_full;
        mem_wr    = inst_wr;
        mem_size  = inst_size;
        mem_addr  = inst_addr;
        mem_wstrb = inst_wstrb;
        mem_wdata = inst_wdata;
      end
      GNT_DATA: begin
        mem_req   = data_req && !fifo_full;
        mem_wr    = data_wr;
        mem_size  = data_size;
        mem_addr  = data_addr;
        mem_wstrb = data_wstrb;
        mem_wdata = data_wdata;
      end
      default: ;
    endcase
  end

  assign accept       = mem_req && mem_addr_ok;
  assign inst_addr_ok = accept && (gnt == GNT_INST);
  assign data_addr_ok = accept && (gnt == GNT_DATA);

  // Responses arrive in acceptance order, so the FIFO head names the owner.
  // Popping is deliberately not fed back into fifo_full this cycle, which
  // keeps mem_data_ok off any combinational path to mem_req.
  assign head_tag     = tag_q[rd_ptr_q];
  assign pop          = mem_data_ok && !fifo_empty && !reset;
  assign inst_data_ok = pop && (head_tag == TAG_INST);
  assign data_data_ok = pop && (head_tag == TAG_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign arb_err      = arb_err_q && !reset;

  // Lock FSM: hold a stalled grant until accepted or the requester gives up.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_req && !mem_addr_ok)
            state_q <= (gnt == GNT_DATA) ? LOCK_DATA : LOCK_INST;
        end
        LOCK_INST: begin
          if (accept || !inst_req) state_q <= IDLE;
        end
        LOCK_DATA: begin
          if (accept || !data_req) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Occupancy next-state: simultaneous push and pop leave the count alone.
  always_comb begin
    count_d = count_q;
    case ({accept, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Tag FIFO control state and the sticky orphan-response flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      arb_err_q <= 1'b0;
    end else begin
      if (accept) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      if (mem_data_ok && fifo_empty) arb_err_q <= 1'b1;
    end
  end

  // Tag storage: written on accept, contents are meaningless until pushed.
  always_ff @(posedge clk) begin
    if (accept) tag_q[wr_ptr_q] <= (gnt == GNT_DATA) ? TAG_DATA : TAG_INST;
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed cycles push expected accepts and
// responses into queues; a monitor on the falling edge pops and compares
// whenever the DUT raises an addr_ok or data_ok.
module tb_sram_port_arbiter;

  logic        clk;
  logic        reset;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata;
  logic [3:0]  inst_wstrb;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic        arb_err;

  sram_port_arbiter #(.OUTSTANDING(2)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .arb_err(arb_err)
  );

  localparam bit T_INST = 1'b0;
  localparam bit T_DATA = 1'b1;

  typedef struct {
    bit          tag;
    logic [31:0] rdata;
  } resp_t;

  bit    acc_q[$];
  resp_t resp_q[$];
  int    n_chk;
  int    n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = 0; inst_wstrb = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = 0; data_wstrb = 0; data_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 32'h0;
  endtask

  task automatic exp_acc(input bit tag);
    acc_q.push_back(tag);
  endtask

  task automatic exp_resp(input bit tag, input logic [31:0] rd);
    resp_t r;
    r.tag = tag;
    r.rdata = rd;
    resp_q.push_back(r);
  endtask

  // Monitor: every addr_ok/data_ok must match the head of its expectation queue.
  always @(negedge clk) begin
    if (inst_addr_ok && data_addr_ok) begin
      n_chk++; n_fail++;
      $display("FAIL both_addr_ok: got 1/1 expected at most one at %0t", $time);
    end else if (inst_addr_ok || data_addr_ok) begin
      n_chk++;
      if (acc_q.size() == 0) begin
        n_fail++;
        $display("FAIL accept_unexpected: got inst=%0b data=%0b expected none at %0t",
                 inst_addr_ok, data_addr_ok, $time);
      end else begin
        bit e;
        e = acc_q.pop_front();
        if (data_addr_ok != e) begin
          n_fail++;
          $display("FAIL accept_owner: got data=%0b expected data=%0b at %0t",
                   data_addr_ok, e, $time);
        end
      end
    end
    if (inst_data_ok && data_data_ok) begin
      n_chk++; n_fail++;
      $display("FAIL both_data_ok: got 1/1 expected at most one at %0t", $time);
    end else if (inst_data_ok || data_data_ok) begin
      n_chk++;
      if (resp_q.size() == 0) begin
        n_fail++;
        $display("FAIL resp_unexpected: got inst=%0b data=%0b expected none at %0t",
                 inst_data_ok, data_data_ok, $time);
      end else begin
        resp_t e;
        e = resp_q.pop_front();
        if (data_data_ok != e.tag ||
            (!e.tag && inst_rdata !== e.rdata) || (e.tag && data_rdata !== e.rdata)) begin
          n_fail++;
          $display("FAIL resp_route: got data=%0b rdata=%h expected data=%0b rdata=%h at %0t",
                   data_data_ok, e.tag ? data_rdata : inst_rdata, e.tag, e.rdata, $time);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit prev;
    n_chk = 0;
    n_fail = 0;
    idle_inputs();
    reset = 1;
    cyc();
    // Reset: request and response activity must be fully masked.
    inst_req = 1; inst_addr = 32'h1234_5678; mem_addr_ok = 1; mem_data_ok = 1;
    mem_rdata = 32'hdead_beef;
    @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_arb_err", arb_err, 0);
    chk("rst_rdata_pass", inst_rdata, 32'hdead_beef);
    cyc();
    reset = 0;
    idle_inputs();
    cyc();

    // T1: single inst read.
    inst_req = 1; inst_addr = 32'h1c00_0000; mem_addr_ok = 1;
    exp_acc(T_INST);
    @(negedge clk);
    chk("t1_mem_req", mem_req, 1);
    chk("t1_mem_addr", mem_addr, 32'h1c00_0000);
    cyc();
    idle_inputs();
    @(negedge clk);
    chk("t1_idle_req", mem_req, 0);
    cyc();
    mem_data_ok = 1; mem_rdata = 32'h1c00_0000;
    exp_resp(T_INST, 32'h1c00_0000);
    cyc();
    idle_inputs();
    cyc();

    // T2: simultaneous requests, data first, responses in order.
    inst_req = 1; inst_addr = 32'h0000_1000;
    data_req = 1; data_addr = 32'h0000_2000; data_wr = 1; data_wstrb = 4'hf;
    data_wdata = 32'hcafe_f00d; mem_addr_ok = 1;
    exp_acc(T_DATA);
    @(negedge clk);
    chk("t2_addr_data", mem_addr, 32'h0000_2000);
    chk("t2_wr_data", mem_wr, 1);
    chk("t2_wdata", mem_wdata, 32'hcafe_f00d);
    cyc();
    data_req = 0;
    exp_acc(T_INST);
    @(negedge clk);
    chk("t2_addr_inst", mem_addr, 32'h0000_1000);
    chk("t2_wr_inst", mem_wr, 0);
    cyc();
    idle_inputs();
    mem_data_ok = 1; mem_rdata = 32'h2222_2222;
    exp_resp(T_DATA, 32'h2222_2222);
    cyc();
    mem_rdata = 32'h1111_1111;
    exp_resp(T_INST, 32'h1111_1111);
    cyc();
    idle_inputs();
    cyc();

    // T3: stalled inst grant is not preempted by a later data request.
    inst_req = 1; inst_addr = 32'h0000_3000; data_addr = 32'h0000_4000;
    @(negedge clk);
    chk("t3_addr_c0", mem_addr, 32'h0000_3000);
    cyc();
    data_req = 1;
    @(negedge clk);
    chk("t3_addr_c1", mem_addr, 32'h0000_3000);
    cyc();
    @(negedge clk);
    chk("t3_addr_c2", mem_addr, 32'h0000_3000);
    cyc();
    mem_addr_ok = 1;
    exp_acc(T_INST);
    @(negedge clk);
    chk("t3_addr_c3", mem_addr, 32'h0000_3000);
    cyc();
    inst_req = 0;
    exp_acc(T_DATA);
    @(negedge clk);
    chk("t3_addr_c4", mem_addr, 32'h0000_4000);
    cyc();
    idle_inputs();
    mem_data_ok = 1; mem_rdata = 32'h3333_3333;
    exp_resp(T_INST, 32'h3333_3333);
    cyc();
    mem_rdata = 32'h4444_4444;
    exp_resp(T_DATA, 32'h4444_4444);
    cyc();
    idle_inputs();
    cyc();

    // T4: FIFO full blocks the third request until a pop has retired.
    inst_req = 1; inst_addr = 32'h0000_5000; mem_addr_ok = 1;
    exp_acc(T_INST);
    cyc();
    inst_req = 0; data_req = 1; data_addr = 32'h0000_6000;
    exp_acc(T_DATA);
    cyc();
    @(negedge clk);
    chk("t4_full_blocks", mem_req, 0);
    cyc();
    mem_data_ok = 1; mem_rdata = 32'h5555_5555;
    exp_resp(T_INST, 32'h5555_5555);
    @(negedge clk);
    chk("t4_no_bypass", mem_req, 0);
    cyc();
    mem_data_ok = 0;
    exp_acc(T_DATA);
    @(negedge clk);
    chk("t4_reopen", mem_req, 1);
    cyc();
    data_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h6666_0001;
    exp_resp(T_DATA, 32'h6666_0001);
    cyc();
    mem_rdata = 32'h6666_0002;
    exp_resp(T_DATA, 32'h6666_0002);
    cyc();
    idle_inputs();
    cyc();

    // T5: steady push+pop with alternating owners, pointers wrap.
    inst_req = 1; inst_addr = 32'h0000_7000; mem_addr_ok = 1;
    exp_acc(T_INST);
    prev = T_INST;
    cyc();
    for (int k = 0; k < 8; k++) begin
      bit cur;
      cur = (k % 2 == 0) ? T_DATA : T_INST;
      inst_req = !cur; data_req = cur;
      data_addr = 32'h0000_8000 + k;
      mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'h5000_0000 + k;
      exp_acc(cur);
      exp_resp(prev, 32'h5000_0000 + k);
      prev = cur;
      @(negedge clk);
      chk("t5_req", mem_req, 1);
      cyc();
    end
    idle_inputs();
    mem_data_ok = 1; mem_rdata = 32'h5000_00ff;
    exp_resp(prev, 32'h5000_00ff);
    cyc();
    idle_inputs();
    cyc();

    // T6: orphan response sets sticky error; reset mid-lock clears it.
    mem_data_ok = 1; mem_rdata = 32'h0bad_0bad;
    cyc();
    mem_data_ok = 0;
    @(negedge clk);
    chk("t6_err_set", arb_err, 1);
    cyc();
    @(negedge clk);
    chk("t6_err_held", arb_err, 1);
    cyc();
    data_req = 1; data_addr = 32'h0000_9000;
    cyc();
    inst_req = 1; inst_addr = 32'h0000_a000; reset = 1;
    @(negedge clk);
    chk("t6_rst_req", mem_req, 0);
    chk("t6_rst_err", arb_err, 0);
    cyc();
    reset = 0; data_req = 0; mem_addr_ok = 1;
    exp_acc(T_INST);
    @(negedge clk);
    chk("t6_fresh_req", mem_req, 1);
    chk("t6_fresh_addr", mem_addr, 32'h0000_a000);
    chk("t6_err_clear", arb_err, 0);
    cyc();
    idle_inputs();
    mem_data_ok = 1; mem_rdata = 32'h0000_a5a5;
    exp_resp(T_INST, 32'h0000_a5a5);
    cyc();
    idle_inputs();
    cyc();
    @(negedge clk);
    chk("end_acc_drained", acc_q.size(), 0);
    chk("end_resp_drained", resp_q.size(), 0);
    chk("end_no_err", arb_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
